// File: rtl/cmp_bsearch_ctrl.sv
// cmp_bsearch_ctrl: binary-search initiator that locates a target behind an LT/EQ/GT comparator.
module cmp_bsearch_ctrl #(
  parameter int W     = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     probe,
  output logic             probe_valid,
  input  logic             cmp_valid,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [W-1:0]     result,
  output logic [CNT_W-1:0] steps
);
  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = '1;
  state_t state;
  logic [W-1:0] lo, hi, lo_n, hi_n, mid_n;
  logic ok, hit, stop;
  assign ok    = $onehot({cmp_lt, cmp_eq, cmp_gt});
  assign hit   = ok && cmp_eq;
  assign lo_n  = cmp_lt ? probe + ONE : lo;
  assign hi_n  = cmp_gt ? probe - ONE : hi;
  assign mid_n = lo_n + ((hi_n - lo_n) >> 1);
  assign stop  = !ok || cmp_eq || (cmp_lt && probe == hi) || (cmp_gt && probe == lo);
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lo          <= '0;
      hi          <= MAX;
      probe       <= '0;
      probe_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      steps       <= '0;
    end else if (state == PROBE) begin
      if (cmp_valid) begin
        steps <= steps + CNT_W'(1);
        if (stop) begin
          state       <= DONE;
          probe_valid <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          found       <= hit;
          err         <= !ok;
          result      <= hit ? probe : '0;
        end else begin
          lo    <= lo_n;
          hi    <= hi_n;
          probe <= mid_n;
        end
      end
    end else begin
      done <= 1'b0;
      if (start) begin
        state       <= PROBE;
        lo          <= '0;
        hi          <= MAX;
        probe       <= MAX >> 1;
        probe_valid <= 1'b1;
        busy        <= 1'b1;
        steps       <= '0;
        found       <= 1'b0;
        err         <= 1'b0;
        result      <= '0;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_cmp_bsearch_ctrl.sv
// tb_cmp_bsearch_ctrl: directed vector bench for cmp_bsearch_ctrl with a modelled comparator.
module tb_cmp_bsearch_ctrl;
  logic clk = 1'b0, rst, start;
  logic [3:0] probe, result;
  logic [2:0] steps;
  logic probe_valid, cmp_valid, cmp_lt, cmp_eq, cmp_gt, busy, done, found, err;
  int mode, target, delay, wcnt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  cmp_bsearch_ctrl #(.W(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .probe(probe), .probe_valid(probe_valid),
    .cmp_valid(cmp_valid), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .busy(busy), .done(done), .found(found), .err(err), .result(result), .steps(steps)
  );
  // mode 0: true comparator, 1: always gt, 2: always lt, 3: lt+gt on 2nd probe, 4: no flags
  assign cmp_valid = probe_valid && (wcnt >= delay);
  assign cmp_lt = mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : (mode == 3 && steps == 3'd1) ? 1'b1 : mode == 4 ? 1'b0 : int'(probe) < target;
  assign cmp_eq = mode == 1 || mode == 2 || (mode == 3 && steps == 3'd1) || mode == 4 ? 1'b0 : int'(probe) == target;
  assign cmp_gt = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : (mode == 3 && steps == 3'd1) ? 1'b1 : mode == 4 ? 1'b0 : int'(probe) > target;
  always @(posedge clk) wcnt <= (rst || !probe_valid || cmp_valid) ? 0 : wcnt + 1;
  typedef struct {
    int mode, target, delay, poke, np;
    int p[6];
    int found, err, result, steps, lat;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string name);
    chk(name, int'({probe, probe_valid, busy, done, found, err, result, steps}), 0);
  endtask
  task automatic run(input vec_t v, input int id);
    int got[6];
    int n = 0, k = 1, pp = 0;
    bit pw = 0;
    mode = v.mode; target = v.target; delay = v.delay;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (k <= 60 && !done) begin
      if (pw) chk($sformatf("v%0d_hold", id), probe, pp);
      if (probe_valid && cmp_valid && n < 6) begin
        got[n] = probe;
        n++;
      end
      pw = probe_valid && !cmp_valid;
      pp = probe;
      start = (k == v.poke);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk($sformatf("v%0d_done", id), done, 1);
    chk($sformatf("v%0d_lat", id), k, v.lat);
    chk($sformatf("v%0d_nprobe", id), n, v.np);
    for (int i = 0; i < v.np && i < n; i++) chk($sformatf("v%0d_probe%0d", id, i), got[i], v.p[i]);
    chk($sformatf("v%0d_found", id), found, v.found);
    chk($sformatf("v%0d_err", id), err, v.err);
    chk($sformatf("v%0d_result", id), result, v.result);
    chk($sformatf("v%0d_steps", id), steps, v.steps);
    chk($sformatf("v%0d_busy", id), busy, 0);
  endtask
  initial begin
    vecs[0] = '{0, 7, 0, 0, 1, '{7, 0, 0, 0, 0, 0}, 1, 0, 7, 1, 2};
    vecs[1] = '{0, 15, 0, 0, 5, '{7, 11, 13, 14, 15, 0}, 1, 0, 15, 5, 6};
    vecs[2] = '{0, 0, 0, 0, 4, '{7, 3, 1, 0, 0, 0}, 1, 0, 0, 4, 5};
    vecs[3] = '{0, 8, 0, 0, 4, '{7, 11, 9, 8, 0, 0}, 1, 0, 8, 4, 5};
    vecs[4] = '{0, 5, 3, 0, 3, '{7, 3, 5, 0, 0, 0}, 1, 0, 5, 3, 13};
    vecs[5] = '{1, 0, 0, 0, 4, '{7, 3, 1, 0, 0, 0}, 0, 0, 0, 4, 5};
    vecs[6] = '{2, 0, 0, 0, 5, '{7, 11, 13, 14, 15, 0}, 0, 0, 0, 5, 6};
    vecs[7] = '{3, 15, 0, 0, 2, '{7, 11, 0, 0, 0, 0}, 0, 1, 0, 2, 3};
    vecs[8] = '{4, 0, 0, 0, 1, '{7, 0, 0, 0, 0, 0}, 0, 1, 0, 1, 2};
    vecs[9] = '{0, 5, 3, 2, 3, '{7, 3, 5, 0, 0, 0}, 1, 0, 5, 3, 13};
    mode = 0; target = 0; delay = 0;
    rst = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk_zero("idle");
    for (int i = 0; i < 10; i++) run(vecs[i], i);
    run(vecs[7], 10);
    mode = 0; target = 7; delay = 0;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("restart_probe", probe, 7);
    chk("restart_pv", probe_valid, 1);
    chk("restart_busy", busy, 1);
    chk("restart_flags", int'({found, err, done}), 0);
    chk("restart_steps", steps, 0);
    @(negedge clk);
    chk("restart_done", done, 1);
    chk("restart_found", found, 1);
    chk("restart_result", result, 7);
    target = 15;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_probe", probe, 13);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk_zero("rst_mid");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_quiet%0d", i), int'({done, busy, probe_valid}), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmp_bsearch_ctrl.md
Name: cmp_bsearch_ctrl

Overview:
- Sequential initiator for the team's magnitude comparator (LT/EQ/GT responder).
- Finds an unknown W-bit target held behind an external comparator by binary search.
- Drives probe values to the comparator's `a` input; the target sits on `b`. Consumes the LT/EQ/GT response and narrows the search bounds each step.
- Reports the found value, a not-found or error status, and the probe count.

Parameters:
- W, 4, operand width; the search range is 0 .. 2^W-1.
- CNT_W, 3, width of the steps counter; must satisfy CNT_W >= clog2(W+2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new search; sampled only when busy=0.
- probe  output  W  value presented to the comparator as operand a.
- probe_valid  output  1  probe is valid; a comparator response is expected.
- cmp_valid  input  1  comparator response valid; sampled only while probe_valid=1.
- cmp_lt  input  1  probe < target.
- cmp_eq  input  1  probe == target.
- cmp_gt  input  1  probe > target.
- busy  output  1  search in progress.
- done  output  1  one-cycle pulse when a search terminates.
- found  output  1  last search hit EQ; held until the next accepted start.
- err  output  1  last search aborted on a malformed response; held until the next accepted start.
- result  output  W  matched value when found=1, else 0; held.
- steps  output  CNT_W  number of accepted responses in the last or current search.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. All outputs are 0: probe, probe_valid, busy, done, found, err, result, steps. Internal lo=0, hi=2^W-1. Reset mid-search abandons the search with no done pulse.
- States:
  - IDLE: busy=0.
  - PROBE: busy=1, probe_valid=1.
  - DONE: busy=0, done=1 for exactly one cycle.
- IDLE/DONE with start=1: on the next cycle, state=PROBE. Set lo=0, hi=2^W-1, probe=(2^W-1)>>1, steps=0, found=0, err=0, result=0.
- DONE with start=0: next state is IDLE.
- PROBE with cmp_valid=0: hold all state and probe; wait indefinitely.
- PROBE with cmp_valid=1: the response is accepted and steps increments.
  - Exactly one of lt/eq/gt must be 1; otherwise err=1, found=0, next state is DONE.
  - eq: found=1, result=probe, next state is DONE.
  - lt and probe==hi: not found, next state is DONE.
  - lt otherwise: lo=probe+1.
  - gt and probe==lo: not found, next state is DONE.
  - gt otherwise: hi=probe-1.
  - When continuing, the new probe is lo'+((hi'-lo')>>1), floor, computed in W bits with no wrap. probe is registered and updates on the acceptance edge. The state stays PROBE.
- Throughput: a responder that holds cmp_valid=1 combinationally allows one probe per cycle. The worst case is W+1 probes.
- Latency: start at cycle t gives the first probe at t+1. With an always-valid responder, done is asserted at t+1+steps.
- probe holds its last value outside PROBE. probe_valid=0 outside PROBE.
- start is ignored while busy=1.

Test Plan:
- Reset check: assert rst with start=1 for 2 cycles -> all outputs 0 and no probe_valid. Then start with target=7 and an always-valid combinational comparator -> probe=7 at t+1, done at t+2, found=1, result=7, steps=1.
- Target=15 -> probe sequence 7,11,13,14,15, done at t+6, found=1, result=15, steps=5. Target=0 -> probes 7,3,1,0, steps=4. Target=8 -> probes 7,11,9,8, steps=4.
- Responder returns cmp_valid after a 3-cycle delay per probe with target=5 -> probe is stable while waiting, probes 7,3,5, found=1, steps=3, done at t+1+3*4.
- Responder always answers gt -> probes 7,3,1,0, then done with found=0, err=0, result=0, steps=4. Responder always answers lt -> probes 7,11,13,14,15, found=0, steps=5.
- Malformed response (lt=1, gt=1) on the 2nd probe -> done the next cycle, err=1, found=0, steps=2. Response with cmp_valid=1 and all flags 0 -> same error path.
- start pulsed while busy -> ignored. start during the done cycle -> new search with probe=7 on the next cycle and found/err/steps cleared. rst during the 3rd probe -> IDLE, all outputs 0, and no done pulse.
